// File: rtl/pipeline_run_ctrl_if.sv
// pipeline_run_ctrl_if
// Groups the debug byte stream, the pipeline run-control outputs and the
// status readout of pipeline_run_ctrl into one bundle.
//   master : the run controller (consumes bytes / prog_done, drives pipeline)
//   slave  : the environment (UART receiver, pipeline, debug readout)
// Signals:
//   i_rx_data/i_rx_valid   received byte + one-cycle strobe
//   i_prog_done            HALT instruction retired (level from WB)
//   o_we_IF/o_instruction_data  instruction memory write port
//   o_halt                 pipeline freeze
//   o_cycle_count          unhalted cycles since last load
//   o_busy/o_done/o_err/o_state  status
interface pipeline_run_ctrl_if #(
  parameter int NB_DATA   = 32,
  parameter int NB_BYTE   = 8,
  parameter int NB_CYCLES = 32
);
  logic [NB_BYTE-1:0]   i_rx_data;
  logic                 i_rx_valid;
  logic                 i_prog_done;
  logic                 o_we_IF;
  logic [NB_DATA-1:0]   o_instruction_data;
  logic                 o_halt;
  logic [NB_CYCLES-1:0] o_cycle_count;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_err;
  logic [2:0]           o_state;

  modport master (
    input  i_rx_data, i_rx_valid, i_prog_done,
    output o_we_IF, o_instruction_data, o_halt, o_cycle_count,
           o_busy, o_done, o_err, o_state
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_prog_done,
    input  o_we_IF, o_instruction_data, o_halt, o_cycle_count,
           o_busy, o_done, o_err, o_state
  );
endinterface

// File: rtl/pipeline_run_ctrl.sv
// pipeline_run_ctrl
// Run-control scheduler for the 5-stage MIPS pipeline. Assembles program
// words from the debug UART byte stream, writes them into IF instruction
// memory, and sequences run / single-step / halt.
// Ports:
//   clk    system clock
//   i_rst  synchronous active-high reset
//   bus    pipeline_run_ctrl_if.master (byte stream in, pipeline control out)
// Build option:
//   PIPELINE_RUN_CTRL_CYCLE_CNT_EN  when defined, builds the saturating
//   unhalted-cycle counter; otherwise o_cycle_count is tied to 0.
//
// state     | meaning
// IDLE      | waiting for a command byte ('L', 'R', 'S')
// LOAD_CNT  | next byte is the word count N (0 -> 256)
// LOAD_BYTE | shifting program bytes MSB-first into words
// RUN       | pipeline free-running until prog_done or 'H'
// STEP      | one unhalted cycle
// DONE      | one-cycle o_done pulse
module pipeline_run_ctrl #(
  parameter int NB_DATA   = 32,
  parameter int NB_BYTE   = 8,
  parameter int NB_CYCLES = 32
) (
  input logic               clk,
  input logic               i_rst,
  pipeline_run_ctrl_if.master bus
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD_CNT  = 3'd1;
  localparam logic [2:0] LOAD_BYTE = 3'd2;
  localparam logic [2:0] RUN       = 3'd3;
  localparam logic [2:0] STEP      = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;

  localparam int BYTES_PER_WORD = NB_DATA / NB_BYTE;
  localparam int NB_BCNT = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(BYTES_PER_WORD - 1);

  localparam logic [NB_BYTE-1:0] CMD_LOAD = NB_BYTE'(8'h4C);
  localparam logic [NB_BYTE-1:0] CMD_RUN  = NB_BYTE'(8'h52);
  localparam logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'(8'h53);
  localparam logic [NB_BYTE-1:0] CMD_HALT = NB_BYTE'(8'h48);

  logic [2:0]                 state_q, state_d;
  logic                       halt_q, halt_d;
  logic                       we_q, we_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;
  logic [NB_DATA-1:0]         instr_q, instr_d;
  logic [NB_DATA-1:0]         word_q, word_d;
  logic [NB_BCNT-1:0]         bcnt_q, bcnt_d;
  logic [8:0]                 wcnt_q, wcnt_d;
  logic [8:0]                 wtot_q, wtot_d;
  logic [NB_DATA+NB_BYTE-1:0] shifted;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    bcnt_d  = bcnt_q;
    wcnt_d  = wcnt_q;
    wtot_d  = wtot_q;
    instr_d = instr_q;
    we_d    = 1'b0;
    err_d   = 1'b0;
    // top NB_BYTE bits fall off: incoming byte lands in the LSBs
    shifted = {word_q, bus.i_rx_data};
    case (state_q)
      IDLE: begin
        if (bus.i_rx_valid) begin
          if (bus.i_rx_data == CMD_LOAD) begin
            state_d = LOAD_CNT;
            wcnt_d  = '0;
            bcnt_d  = '0;
            word_d  = '0;
          end else if (bus.i_rx_data == CMD_RUN) begin
            state_d = RUN;
          end else if (bus.i_rx_data == CMD_STEP) begin
            state_d = STEP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD_CNT: begin
        if (bus.i_rx_valid) begin
          wtot_d  = (bus.i_rx_data == '0) ? 9'd256 : 9'(bus.i_rx_data);
          state_d = LOAD_BYTE;
        end
      end
      LOAD_BYTE: begin
        if (bus.i_rx_valid) begin
          word_d = shifted[NB_DATA-1:0];
          if (bcnt_q == LAST_BYTE) begin
            bcnt_d  = '0;
            we_d    = 1'b1;
            instr_d = shifted[NB_DATA-1:0];
            wcnt_d  = wcnt_q + 9'd1;
            if (wcnt_q + 9'd1 == wtot_q) state_d = IDLE;
          end else begin
            bcnt_d = bcnt_q + NB_BCNT'(1);
          end
        end
      end
      RUN: begin
        // prog_done has priority over a simultaneous 'H'
        if (bus.i_prog_done)
          state_d = DONE;
        else if (bus.i_rx_valid && bus.i_rx_data == CMD_HALT)
          state_d = IDLE;
      end
      STEP:    state_d = bus.i_prog_done ? DONE : IDLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // halt and done are registered from the next state so they line up
    // with the cycle the FSM actually sits in RUN/STEP/DONE
    halt_d = !(state_d == RUN || state_d == STEP);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      halt_q  <= 1'b1;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      instr_q <= '0;
      word_q  <= '0;
      bcnt_q  <= '0;
      wcnt_q  <= '0;
      wtot_q  <= '0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
      instr_q <= instr_d;
      word_q  <= word_d;
      bcnt_q  <= bcnt_d;
      wcnt_q  <= wcnt_d;
      wtot_q  <= wtot_d;
    end
  end

`ifdef PIPELINE_RUN_CTRL_CYCLE_CNT_EN
  logic [NB_CYCLES-1:0] cnt_q;
  logic                 cnt_clr;

  assign cnt_clr = (state_q == IDLE) && bus.i_rx_valid && (bus.i_rx_data == CMD_LOAD);

  always_ff @(posedge clk) begin
    if (i_rst)
      cnt_q <= '0;
    else if (cnt_clr)
      cnt_q <= '0;
    else if (!halt_q && cnt_q != '1)
      cnt_q <= cnt_q + NB_CYCLES'(1);
  end

  assign bus.o_cycle_count = cnt_q;
`else
  assign bus.o_cycle_count = '0;
`endif

  assign bus.o_we_IF            = we_q;
  assign bus.o_instruction_data = instr_q;
  assign bus.o_halt             = halt_q;
  assign bus.o_busy             = (state_q != IDLE);
  assign bus.o_done             = done_q;
  assign bus.o_err              = err_q;
  assign bus.o_state            = state_q;
endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// tb_pipeline_run_ctrl
// Directed bench for pipeline_run_ctrl: a vector table for single-cycle
// behaviour plus hand-written run, step, back-to-back load and reset
// sequences. Inputs change on the falling edge, outputs are sampled on the
// falling edge after the rising edge that consumed them.
module tb_pipeline_run_ctrl;
`ifdef PIPELINE_RUN_CTRL_CYCLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        pd;
    logic        we;
    logic [31:0] dat;
    logic        halt;
    logic [2:0]  st;
    logic        dn;
    logic        er;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t tbl[$];

  pipeline_run_ctrl_if #(.NB_DATA(32), .NB_BYTE(8), .NB_CYCLES(32)) bus ();

  pipeline_run_ctrl #(.NB_DATA(32), .NB_BYTE(8), .NB_CYCLES(32)) dut (
    .clk   (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic pd, input logic we,
                     input logic [31:0] dat, input logic halt, input logic [2:0] st,
                     input logic dn, input logic er);
    vec_t x;
    x.v = v; x.d = d; x.pd = pd; x.we = we; x.dat = dat;
    x.halt = halt; x.st = st; x.dn = dn; x.er = er;
    tbl.push_back(x);
  endtask

  // drive inputs at a falling edge, return at the next falling edge
  task automatic cyc(input logic v, input logic [7:0] d, input logic pd);
    bus.i_rx_valid  = v;
    bus.i_rx_data   = d;
    bus.i_prog_done = pd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] exp_word(input int w);
    logic [7:0] b;
    b = 8'(w);
    return {b, ~b, 8'hA5, b + 8'd1};
  endfunction

  function automatic logic [7:0] byte_of(input int k);
    logic [31:0] wd;
    wd = exp_word(k / 4);
    return wd[31 - 8 * (k % 4) -: 8];
  endfunction

  initial begin
    int cnt_exp;
    int lows;
    int n_we;
    int bad_data;
    int halt_viol;
    int we_seen;

    bus.i_rx_valid  = 1'b0;
    bus.i_rx_data   = 8'h00;
    bus.i_prog_done = 1'b0;

    //   v  d      pd we dat           halt st dn er
    add(1, 8'h4C, 0, 0, 32'h0,        1, 1, 0, 0);
    add(1, 8'h02, 0, 0, 32'h0,        1, 2, 0, 0);
    add(1, 8'h20, 0, 0, 32'h0,        1, 2, 0, 0);
    add(1, 8'h08, 0, 0, 32'h0,        1, 2, 0, 0);
    add(1, 8'h00, 0, 0, 32'h0,        1, 2, 0, 0);
    add(1, 8'h05, 0, 1, 32'h20080005, 1, 2, 0, 0);
    add(1, 8'h00, 0, 0, 32'h20080005, 1, 2, 0, 0);
    add(1, 8'h00, 0, 0, 32'h20080005, 1, 2, 0, 0);
    add(1, 8'h00, 0, 0, 32'h20080005, 1, 2, 0, 0);
    add(1, 8'h0C, 0, 1, 32'h0000000C, 1, 0, 0, 0);
    add(0, 8'h00, 0, 0, 32'h0000000C, 1, 0, 0, 0);
    add(1, 8'h7F, 0, 0, 32'h0000000C, 1, 0, 0, 1);
    add(0, 8'h00, 0, 0, 32'h0000000C, 1, 0, 0, 0);
    add(0, 8'h00, 1, 0, 32'h0000000C, 1, 0, 0, 0);
    add(1, 8'h52, 0, 0, 32'h0000000C, 0, 3, 0, 0);
    add(1, 8'h4C, 0, 0, 32'h0000000C, 0, 3, 0, 0);
    add(1, 8'h48, 1, 0, 32'h0000000C, 1, 5, 1, 0);
    add(0, 8'h00, 0, 0, 32'h0000000C, 1, 0, 0, 0);
    add(1, 8'h52, 0, 0, 32'h0000000C, 0, 3, 0, 0);
    add(1, 8'h48, 0, 0, 32'h0000000C, 1, 0, 0, 0);
    add(0, 8'h00, 0, 0, 32'h0000000C, 1, 0, 0, 0);
    add(1, 8'h53, 0, 0, 32'h0000000C, 0, 4, 0, 0);
    add(0, 8'h00, 1, 0, 32'h0000000C, 1, 5, 1, 0);
    add(0, 8'h00, 0, 0, 32'h0000000C, 1, 0, 0, 0);
    add(1, 8'h53, 0, 0, 32'h0000000C, 0, 4, 0, 0);
    add(1, 8'h52, 0, 0, 32'h0000000C, 1, 0, 0, 0);
    add(0, 8'h00, 0, 0, 32'h0000000C, 1, 0, 0, 0);

    // reset state
    @(negedge clk);
    cyc(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    chk("rst_state", 64'(bus.o_state), 64'd0);
    chk("rst_halt",  64'(bus.o_halt), 64'd1);
    chk("rst_we",    64'(bus.o_we_IF), 64'd0);
    chk("rst_data",  64'(bus.o_instruction_data), 64'd0);
    chk("rst_cnt",   64'(bus.o_cycle_count), 64'd0);
    chk("rst_busy",  64'(bus.o_busy), 64'd0);
    chk("rst_done",  64'(bus.o_done), 64'd0);
    chk("rst_err",   64'(bus.o_err), 64'd0);

    // table: load, error byte, run/halt, step, ignored inputs
    cnt_exp = 0;
    foreach (tbl[i]) begin
      if (i > 0 && !tbl[i-1].halt) cnt_exp++;
      cyc(tbl[i].v, tbl[i].d, tbl[i].pd);
      chk($sformatf("v%0d_we", i),    64'(bus.o_we_IF), 64'(tbl[i].we));
      chk($sformatf("v%0d_data", i),  64'(bus.o_instruction_data), 64'(tbl[i].dat));
      chk($sformatf("v%0d_halt", i),  64'(bus.o_halt), 64'(tbl[i].halt));
      chk($sformatf("v%0d_state", i), 64'(bus.o_state), 64'(tbl[i].st));
      chk($sformatf("v%0d_busy", i),  64'(bus.o_busy), 64'(tbl[i].st != 3'd0));
      chk($sformatf("v%0d_done", i),  64'(bus.o_done), 64'(tbl[i].dn));
      chk($sformatf("v%0d_err", i),   64'(bus.o_err), 64'(tbl[i].er));
      chk($sformatf("v%0d_cnt", i),   64'(bus.o_cycle_count), CNT_EN ? 64'(cnt_exp) : 64'd0);
    end

    // run for 10 cycles, then prog_done
    do_reset();
    cyc(1'b1, 8'h52, 1'b0);
    lows = 0;
    for (int k = 0; k < 10; k++) begin
      if (!bus.o_halt) lows++;
      cyc(1'b0, 8'h00, k == 9);
    end
    chk("run_halt_low_cycles", 64'(lows), 64'd10);
    chk("run_state_done", 64'(bus.o_state), 64'd5);
    chk("run_done_pulse", 64'(bus.o_done), 64'd1);
    chk("run_halt_after", 64'(bus.o_halt), 64'd1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("run_idle", 64'(bus.o_state), 64'd0);
    chk("run_done_clear", 64'(bus.o_done), 64'd0);
    chk("run_cnt", 64'(bus.o_cycle_count), CNT_EN ? 64'd10 : 64'd0);

    // three steps, 5 cycles apart
    do_reset();
    lows = 0;
    for (int s = 0; s < 3; s++) begin
      cyc(1'b1, 8'h53, 1'b0);
      if (!bus.o_halt) lows++;
      for (int k = 0; k < 4; k++) begin
        cyc(1'b0, 8'h00, 1'b0);
        if (!bus.o_halt) lows++;
      end
    end
    chk("step_halt_low_cycles", 64'(lows), 64'd3);
    chk("step_cnt", 64'(bus.o_cycle_count), CNT_EN ? 64'd3 : 64'd0);

    // back-to-back load of 256 words (N=0), valid held high
    cyc(1'b1, 8'h4C, 1'b0);
    chk("load_clears_cnt", 64'(bus.o_cycle_count), 64'd0);
    cyc(1'b1, 8'h00, 1'b0);
    n_we = 0; bad_data = 0; halt_viol = 0;
    for (int k = 0; k < 1024 + 2; k++) begin
      if (k < 1024) cyc(1'b1, byte_of(k), 1'b0);
      else          cyc(1'b0, 8'h00, 1'b0);
      if (!bus.o_halt) halt_viol++;
      if (bus.o_we_IF === 1'b1) begin
        if (bus.o_instruction_data !== exp_word(n_we)) begin
          if (bad_data == 0)
            $display("word %0d: got 0x%08h want 0x%08h", n_we, bus.o_instruction_data, exp_word(n_we));
          bad_data++;
        end
        n_we++;
      end
    end
    chk("b2b_we_pulses", 64'(n_we), 64'd256);
    chk("b2b_bad_words", 64'(bad_data), 64'd0);
    chk("b2b_halt_low", 64'(halt_viol), 64'd0);
    chk("b2b_state_idle", 64'(bus.o_state), 64'd0);

    // reset after 2 of 4 bytes, then a fresh load
    we_seen = 0;
    cyc(1'b1, 8'h4C, 1'b0);
    cyc(1'b1, 8'h01, 1'b0);
    cyc(1'b1, 8'hDE, 1'b0);
    if (bus.o_we_IF === 1'b1) we_seen++;
    cyc(1'b1, 8'hAD, 1'b0);
    if (bus.o_we_IF === 1'b1) we_seen++;
    rst = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    if (bus.o_we_IF === 1'b1) we_seen++;
    rst = 1'b0;
    chk("midrst_state", 64'(bus.o_state), 64'd0);
    chk("midrst_halt", 64'(bus.o_halt), 64'd1);
    chk("midrst_data", 64'(bus.o_instruction_data), 64'd0);
    cyc(1'b0, 8'h00, 1'b0);
    if (bus.o_we_IF === 1'b1) we_seen++;
    chk("midrst_no_we", 64'(we_seen), 64'd0);
    cyc(1'b1, 8'h4C, 1'b0);
    cyc(1'b1, 8'h01, 1'b0);
    cyc(1'b1, 8'h12, 1'b0);
    cyc(1'b1, 8'h34, 1'b0);
    cyc(1'b1, 8'h56, 1'b0);
    chk("reload_no_early_we", 64'(bus.o_we_IF), 64'd0);
    cyc(1'b1, 8'h78, 1'b0);
    chk("reload_we", 64'(bus.o_we_IF), 64'd1);
    chk("reload_data", 64'(bus.o_instruction_data), 64'h12345678);
    chk("reload_state", 64'(bus.o_state), 64'd0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("reload_we_single", 64'(bus.o_we_IF), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
